// File: rtl/lut_multiplier.sv
// Pipelined signed fixed-point multiplier: a * sign-extended coefficient b[CONST_W-1:0].
// The product is built from a 16-entry table of a's digit multiples and a shift-add tree.
module lut_multiplier #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16,
  parameter int FRAC    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic [IN_W-1:0] result
);

  localparam int D   = (CONST_W + 3) / 4;
  localparam int CW4 = 4 * D;
  localparam int LW  = IN_W + 4;
  // One spare bit above the exact product keeps the rounding add from wrapping.
  localparam int PW  = IN_W + CW4 + 1;
  localparam logic signed [PW-1:0] RND = PW'((64'd1 << FRAC) >> 1);

  logic signed [LW-1:0]      a_ext_s;
  logic signed [LW-1:0]      lut_d [16];
  logic signed [LW-1:0]      lut_q [16];
  logic signed [CONST_W-1:0] c_d;
  logic signed [CONST_W-1:0] c_q;
  logic                      b_unused_s;

  logic [CW4-1:0]            c_ext_s;
  logic [3:0]                digit_s;
  logic [3:0]                mag_s;
  logic signed [PW-1:0]      term_s;
  logic signed [PW-1:0]      prod_s;
  logic signed [PW-1:0]      rnd_s;
  logic signed [PW-1:0]      r_s;
  logic [IN_W-1:0]           result_d;
  logic [IN_W-1:0]           result_q;

  assign a_ext_s    = {{4{a[IN_W-1]}}, a};
  assign c_d        = b[CONST_W-1:0];
  assign b_unused_s = ^b;

  // Table of k*a for k = 0..15, formed from shifted copies of a.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      lut_d[k] = '0;
      for (int j = 0; j < 4; j++) begin
        if (((k >> j) & 1) == 1) begin
          lut_d[k] = lut_d[k] + (a_ext_s <<< j);
        end else begin
          lut_d[k] = lut_d[k];
        end
      end
    end
  end

  // Stage 1: capture the coefficient and the multiple table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        lut_q[k] <= '0;
      end
      c_q <= '0;
    end else begin
      lut_q <= lut_d;
      c_q   <= c_d;
    end
  end

  assign c_ext_s = CW4'(c_q);

  // Shift-add of radix-16 digits; only the top digit carries a sign.
  always_comb begin
    prod_s  = '0;
    digit_s = '0;
    mag_s   = '0;
    term_s  = '0;
    for (int i = 0; i < D; i++) begin
      digit_s = c_ext_s[4*i +: 4];
      if ((i == D - 1) && digit_s[3]) begin
        mag_s  = ~digit_s + 4'd1;
        term_s = -PW'(lut_q[mag_s]);
      end else begin
        mag_s  = digit_s;
        term_s = PW'(lut_q[digit_s]);
      end
      prod_s = prod_s + (term_s <<< (4 * i));
    end
    rnd_s = prod_s + RND;
    r_s   = rnd_s >>> FRAC;
  end

  // Saturate whenever the bits above the result's sign bit disagree with it.
  always_comb begin
    if ((&r_s[PW-1:IN_W-1]) || (~|r_s[PW-1:IN_W-1])) begin
      result_d = r_s[IN_W-1:0];
    end else if (r_s[PW-1]) begin
      result_d = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      result_d = {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  // Stage 2: registered, rounded and saturated product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_lut_multiplier.sv
// Directed and back-to-back random checks of lut_multiplier for the 20/15, 4/0 and 32/31 configurations.
module tb_lut_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res20;
  logic [31:0] res4;
  logic [31:0] res32;
  int          checks;
  int          errors;

  lut_multiplier #(.IN_W(32), .CONST_W(20), .FRAC(15)) u_dut20 (
    .clk(clk), .rst(rst), .a(a), .b(b), .result(res20));
  lut_multiplier #(.IN_W(32), .CONST_W(4), .FRAC(0)) u_dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .result(res4));
  lut_multiplier #(.IN_W(32), .CONST_W(32), .FRAC(31)) u_dut32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .result(res32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: full-precision multiply, round half up, saturate.
  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input int cw, input int frac);
    longint c;
    longint p;
    longint r;
    c = longint'($signed(bv));
    c = (c <<< (64 - cw)) >>> (64 - cw);
    p = longint'($signed(av)) * c;
    if (frac > 0) p = p + (longint'(1) <<< (frac - 1));
    r = p >>> frac;
    if (r > 64'sd2147483647) return 32'h7FFFFFFF;
    else if (r < -64'sd2147483648) return 32'h80000000;
    else return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic vec20(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp);
    a = av;
    b = bv;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, res20, exp);
  endtask

  logic [31:0] qa [$];
  logic [31:0] qb [$];
  logic [31:0] ea;
  logic [31:0] eb;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = 32'h0;
    b = 32'h0;

    // Operands toggle while reset is held.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      check("rst_hold", res20, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    a = 32'h00010000;
    b = 32'h00008000;
    check("rst_release", res20, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge1", res20, 32'h0);
    @(posedge clk);
    #1;
    check("rst_first_op", res20, 32'h00010000);

    vec20("neg_lsb",      32'h00008000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    vec20("zero_in",      32'h00000000, 32'hFFFFFFFF, 32'h00000000);
    vec20("unit",         32'h00010000, 32'h00008000, 32'h00010000);
    vec20("frac",         32'hFFFF8000, 32'h00004000, 32'hFFFFC000);
    vec20("c_min",        32'h00008000, 32'h00180000, 32'hFFF80000);
    vec20("sat_pos",      32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF);
    vec20("sat_neg",      32'h80000000, 32'h00010000, 32'h80000000);
    vec20("sat_min_neg",  32'h80000000, 32'h000F8000, 32'h7FFFFFFF);

    a = 32'h00000005;
    b = 32'h0000000F;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("w4_neg1", res4, 32'hFFFFFFFB);
    a = 32'h40000000;
    b = 32'h40000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("w32_quarter", res32, 32'h20000000);

    // Reset in the middle of an operation discards it.
    a = 32'h00010000;
    b = 32'h00008000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_async", res20, 32'h0);
    #1;
    rst = 1'b0;
    a = 32'h0;
    b = 32'h0;
    @(posedge clk);
    #1;
    check("mid_rst_flush1", res20, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_flush2", res20, 32'h0);

    // Back-to-back operands, each checked two edges after it is applied.
    for (int n = 0; n < 202; n++) begin
      @(posedge clk);
      #1;
      if (n >= 2) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("rand_w20", res20, model(ea, eb, 20, 15));
        check("rand_w4",  res4,  model(ea, eb, 4, 0));
        check("rand_w32", res32, model(ea, eb, 32, 31));
      end
      if (n < 200) begin
        a = ((n % 8) == 3) ? 32'h80000000 : $urandom;
        b = ((n % 8) == 5) ? 32'h00080000 : $urandom;
        qa.push_back(a);
        qb.push_back(b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
